mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execution stage; consumes its result bundle (wd, wreg, wdata, inst_valid, inst_pc) plus load/store op, address and store data.
- Runs LoongArch-style byte/half/word loads and stores over an SRAM-like data bus: req/addr_ok address phase, then data_ok data phase.
- Passes non-memory results through a single-entry output register to writeback, with valid/ready handshakes on both sides.

Parameters:
- ADDR_W, 32, data address and PC width.
- DATA_W, 32, register and bus data width (32 only).
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  kill in-flight and held instruction
- in_valid_i  in  1  EX bundle valid
- in_ready_o  out  1  stage accepts bundle this cycle
- mem_op_i  in  4  memory op code (package constants)
- mem_addr_i  in  32  effective address
- st_data_i  in  32  store source register
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  EX result
- inst_pc_i  in  32  instruction PC
- out_valid_o  out  1  WB bundle valid
- out_ready_i  in  1  WB accepts
- wd_o  out  5
- wreg_o  out  1
- wdata_o  out  32  EX result or extended load data
- inst_pc_o  out  32
- ale_o  out  1  misaligned-address exception
- bad_addr_o  out  32  faulting address
- data_req_o  out  1
- data_we_o  out  1
- data_addr_o  out  32  word-aligned address
- data_wstrb_o  out  4
- data_wdata_o  out  32  store data replicated to lanes
- data_addr_ok_i  in  1
- data_rdata_i  in  32
- data_data_ok_i  in  1

Behaviour:
- Op codes: NONE=0, LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W.
- States: IDLE, ADDR, DATA, HOLD.
- in_ready_o = (IDLE) or (HOLD and out_ready_i). out_valid_o = (HOLD and not kill).
- Reset: state IDLE, kill=0, all outputs 0.
- Accept with op NONE: register bundle, go HOLD. out_valid_o rises the next cycle, so latency is 1.
- Accept with misaligned memory op (H: addr[0]=1; W: addr[1:0]!=0): no bus request. Go HOLD with ale_o=1, wreg_o=0, bad_addr_o=addr.
- Accept with aligned memory op: go ADDR.
  - ADDR: data_req_o=1 with registered addr/we/wstrb/wdata, all stable until data_addr_ok_i.
  - On addr_ok, go DATA; req drops the same cycle addr_ok is sampled.
- DATA: wait data_data_ok_i.
  - Load: pick lane addr[1:0], sign- or zero-extend, write into wdata_o.
  - Store: wreg_o=0.
  - Then go HOLD.
- ADDR/DATA with addr_ok and data_ok in the same cycle: only addr_ok is honoured in ADDR; data_ok is first sampled in DATA.
- Load-to-WB minimum latency: 3 cycles after accept, with addr_ok and data_ok each arriving in their first possible cycle.
- wstrb: ST_B = 1<<addr[1:0]; ST_H = 2'b11<<addr[1:0]; ST_W = 4'hF. Loads use wstrb 0, we 0.
- HOLD: leave when out_ready_i; go IDLE, or reload directly if a new bundle is accepted the same cycle. The bundle stays stable until taken.
- flush_i:
  - In IDLE or HOLD: go IDLE the next cycle; a bundle presented that cycle is not accepted (in_ready_o forced 0).
  - In ADDR or DATA: set kill. The bus transaction completes normally, since requests cannot be withdrawn. At data_ok, go IDLE with no out_valid, then clear kill.
  - in_ready_o is 0 while kill=1.
- Reset mid-transaction returns to IDLE; the bus side is reset together with the core.

Decomposition:
- Package mem_pkg: mem_op codes, state encoding, and is_load / is_store / access-size helper functions.
- Sub-module mem_load_align: combinational lane select and extension of rdata by addr[1:0] and op. Also used by a later data cache.

Test Plan:
- Non-mem: wdata_i=0x1234, wd=5, wreg=1, out_ready=1 -> next cycle out_valid=1, wdata_o=0x1234, no data_req.
- LD_B at 0x1003 with rdata=0x80FF_0000, addr_ok and data_ok after 1 cycle each -> data_addr=0x1000, wdata_o=0xFFFF_FF80. Repeat with LD_BU -> 0x0000_0080.
- ST_H at 0x2002, st_data=0xABCD -> req=1, we=1, wstrb=4'b1100, wdata=0xABCD_ABCD; held stable while addr_ok is withheld 3 cycles; output wreg_o=0.
- LD_W at 0x3001 -> no req, out_valid with ale_o=1, bad_addr=0x3001, wreg_o=0.
- flush in DATA of LD_W -> in_ready=0 until data_ok; no out_valid; next bundle accepted the cycle after.
- Back-to-back non-mem with out_ready toggling 1,0,1 -> no bundle lost or duplicated; in_ready=0 while HOLD and out_ready=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage: op codes, FSM states,
// bus request payload and op classification functions.
package mem_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
   localparam logic [OP_W-1:0] OP_LD_B  = 4'd1;
   localparam logic [OP_W-1:0] OP_LD_H  = 4'd2;
   localparam logic [OP_W-1:0] OP_LD_W  = 4'd3;
   localparam logic [OP_W-1:0] OP_LD_BU = 4'd4;
   localparam logic [OP_W-1:0] OP_LD_HU = 4'd5;
   localparam logic [OP_W-1:0] OP_ST_B  = 4'd6;
   localparam logic [OP_W-1:0] OP_ST_H  = 4'd7;
   localparam logic [OP_W-1:0] OP_ST_W  = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD} mem_state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] wstrb;
      logic [DATA_W-1:0] wdata;
   } bus_req_t;

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return op inside {OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU};
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return op inside {OP_ST_B, OP_ST_H, OP_ST_W};
   endfunction

   function automatic mem_size_e access_size(input logic [OP_W-1:0] op);
      case (op)
         OP_LD_B, OP_LD_BU, OP_ST_B: return SZ_B;
         OP_LD_H, OP_LD_HU, OP_ST_H: return SZ_H;
         default:                    return SZ_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] off);
      case (access_size(op))
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [OP_W-1:0]   op_i,
   input  logic [1:0]        off_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] ld_data_c_o
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c = rdata_i[7:0];
      case (off_i)
         2'd1:    byte_c = rdata_i[15:8];
         2'd2:    byte_c = rdata_i[23:16];
         2'd3:    byte_c = rdata_i[31:24];
         default: byte_c = rdata_i[7:0];
      endcase
      half_c = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      ld_data_c_o = rdata_i;
      case (op_i)
         OP_LD_B:  ld_data_c_o = {{24{byte_c[7]}}, byte_c};
         OP_LD_BU: ld_data_c_o = {24'h0, byte_c};
         OP_LD_H:  ld_data_c_o = {{16{half_c[15]}}, half_c};
         OP_LD_HU: ld_data_c_o = {16'h0, half_c};
         default:  ld_data_c_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores over a req/addr_ok + data_ok bus and
// hands results to writeback through a single-entry output register.
module mem_stage
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [OP_W-1:0]   mem_op_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] st_data_i,
   input  logic [REG_AW-1:0] wd_i,
   input  logic              wreg_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] inst_pc_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [REG_AW-1:0] wd_o,
   output logic              wreg_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              ale_o,
   output logic [ADDR_W-1:0] bad_addr_o,
   output logic              data_req_o,
   output logic              data_we_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [STRB_W-1:0] data_wstrb_o,
   output logic [DATA_W-1:0] data_wdata_o,
   input  logic              data_addr_ok_i,
   input  logic [DATA_W-1:0] data_rdata_i,
   input  logic              data_data_ok_i
);

   mem_state_e        state_q;
   logic              kill_q;
   logic [OP_W-1:0]   op_q;
   logic [1:0]        off_q;
   logic              req_q;
   bus_req_t          bus_q;
   bus_req_t          bus_d;
   logic [REG_AW-1:0] wd_q;
   logic              wreg_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-1:0] pc_q;
   logic              ale_q;
   logic [ADDR_W-1:0] bad_addr_q;
   logic              accept_c;
   logic              is_mem_c;
   logic              mis_c;
   logic [DATA_W-1:0] ld_data_c;

   assign in_ready_o = !flush_i && !kill_q &&
                       ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready_i));
   assign accept_c   = in_valid_i && in_ready_o;

   // Classify the incoming op and build its bus request.
   always_comb begin
      bus_d      = '0;
      is_mem_c   = is_load(mem_op_i) || is_store(mem_op_i);
      mis_c      = is_mem_c && is_misaligned(mem_op_i, mem_addr_i[1:0]);
      bus_d.addr = {mem_addr_i[ADDR_W-1:2], 2'b00};
      if (is_store(mem_op_i)) begin
         bus_d.we = 1'b1;
         case (access_size(mem_op_i))
            SZ_B: begin
               bus_d.wstrb = STRB_W'(4'b0001 << mem_addr_i[1:0]);
               bus_d.wdata = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
               bus_d.wstrb = STRB_W'(4'b0011 << mem_addr_i[1:0]);
               bus_d.wdata = {2{st_data_i[15:0]}};
            end
            default: begin
               bus_d.wstrb = '1;
               bus_d.wdata = st_data_i;
            end
         endcase
      end
   end

   mem_load_align u_load_align (
      .op_i        (op_q),
      .off_i       (off_q),
      .rdata_i     (data_rdata_i),
      .ld_data_c_o (ld_data_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         kill_q     <= 1'b0;
         op_q       <= OP_NONE;
         off_q      <= 2'b00;
         req_q      <= 1'b0;
         bus_q      <= '0;
         wd_q       <= '0;
         wreg_q     <= 1'b0;
         wdata_q    <= '0;
         pc_q       <= '0;
         ale_q      <= 1'b0;
         bad_addr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: state_q <= S_IDLE;
            S_ADDR: begin
               if (flush_i) kill_q <= 1'b1;
               if (data_addr_ok_i) begin
                  req_q   <= 1'b0;
                  state_q <= S_DATA;
               end
            end
            // A killed transaction still drains its data phase before retiring.
            S_DATA: begin
               if (data_data_ok_i) begin
                  if (kill_q || flush_i) begin
                     kill_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     if (is_load(op_q)) wdata_q <= ld_data_c;
                     else               wreg_q  <= 1'b0;
                     state_q <= S_HOLD;
                  end
               end else if (flush_i) begin
                  kill_q <= 1'b1;
               end
            end
            S_HOLD: if (flush_i || out_ready_i) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase

         // Acceptance only happens from IDLE/HOLD and overrides their exit.
         if (accept_c) begin
            wd_q       <= wd_i;
            wreg_q     <= wreg_i;
            wdata_q    <= wdata_i;
            pc_q       <= inst_pc_i;
            op_q       <= mem_op_i;
            off_q      <= mem_addr_i[1:0];
            ale_q      <= 1'b0;
            bad_addr_q <= '0;
            if (mis_c) begin
               ale_q      <= 1'b1;
               wreg_q     <= 1'b0;
               bad_addr_q <= mem_addr_i;
               state_q    <= S_HOLD;
            end else if (is_mem_c) begin
               req_q   <= 1'b1;
               bus_q   <= bus_d;
               state_q <= S_ADDR;
            end else begin
               state_q <= S_HOLD;
            end
         end
      end
   end

   assign out_valid_o  = (state_q == S_HOLD) && !kill_q;
   assign wd_o         = wd_q;
   assign wreg_o       = wreg_q;
   assign wdata_o      = wdata_q;
   assign inst_pc_o    = pc_q;
   assign ale_o        = ale_q;
   assign bad_addr_o   = bad_addr_q;
   assign data_req_o   = req_q;
   assign data_we_o    = bus_q.we;
   assign data_addr_o  = bus_q.addr;
   assign data_wstrb_o = bus_q.wstrb;
   assign data_wdata_o = bus_q.wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic [4:0]  wd;
   logic        wreg;
   logic [31:0] wdata;
   logic [31:0] pc;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  wd_out;
   logic        wreg_out;
   logic [31:0] wdata_out;
   logic [31:0] pc_out;
   logic        ale;
   logic [31:0] bad_addr;
   logic        req;
   logic        we;
   logic [31:0] bus_addr;
   logic [3:0]  wstrb;
   logic [31:0] bus_wdata;
   logic        addr_ok;
   logic [31:0] rdata;
   logic        data_ok;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .mem_op_i(op), .mem_addr_i(addr), .st_data_i(st_data),
      .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata), .inst_pc_i(pc),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .wd_o(wd_out), .wreg_o(wreg_out), .wdata_o(wdata_out), .inst_pc_o(pc_out),
      .ale_o(ale), .bad_addr_o(bad_addr),
      .data_req_o(req), .data_we_o(we), .data_addr_o(bus_addr),
      .data_wstrb_o(wstrb), .data_wdata_o(bus_wdata),
      .data_addr_ok_i(addr_ok), .data_rdata_i(rdata), .data_data_ok_i(data_ok)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: access size in bytes (0 = no memory access).
   function automatic int size_of(input logic [3:0] o);
      case (o)
         4'd1, 4'd4, 4'd6: return 1;
         4'd2, 4'd5, 4'd7: return 2;
         4'd3, 4'd8:       return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] rd);
      int          n = size_of(o);
      logic [31:0] v = rd >> (8 * int'(a[1:0]));
      logic [31:0] m;
      if (n == 4) return v;
      m = 32'((64'd1 << (8 * n)) - 64'd1);
      v = v & m;
      if ((o == 4'd1 || o == 4'd2) && ((v & ~(m >> 1)) != 0)) v = v | ~m;
      return v;
   endfunction

   function automatic logic [3:0] ref_strb(input logic [3:0] o, input logic [31:0] a);
      int n = size_of(o);
      return 4'(((1 << n) - 1) << int'(a[1:0]));
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [3:0] o, input logic [31:0] s);
      case (size_of(o))
         1:       return (s & 32'hFF) * 32'h0101_0101;
         2:       return (s & 32'hFFFF) * 32'h0001_0001;
         default: return s;
      endcase
   endfunction

   // One complete transaction from an idle stage back to idle.
   task automatic run_txn(input logic [3:0] t_op, input logic [31:0] t_addr,
                          input logic [31:0] t_st, input logic [31:0] t_wdata,
                          input logic [4:0] t_wd, input logic t_wreg,
                          input logic [31:0] t_pc, input logic [31:0] t_rdata,
                          input int a_dly, input int d_dly, input bit rnd_ready);
      int          n     = size_of(t_op);
      bit          is_ld = (t_op >= 4'd1) && (t_op <= 4'd5);
      bit          mis   = (n != 0) && ((int'(t_addr[1:0]) % n) != 0);
      bit          bus   = (n != 0) && !mis;
      logic [31:0] e_wdata = t_wdata;
      logic        e_wreg  = t_wreg;
      logic [31:0] e_bad   = 32'h0;
      bit          done    = 0;
      if (mis) begin
         e_wreg = 1'b0;
         e_bad  = t_addr;
      end else if (bus) begin
         if (is_ld) e_wdata = ref_load(t_op, t_addr, t_rdata);
         else       e_wreg  = 1'b0;
      end

      in_valid = 1'b1; op = t_op; addr = t_addr; st_data = t_st;
      wdata = t_wdata; wd = t_wd; wreg = t_wreg; pc = t_pc;
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;

      if (bus) begin
         for (int i = 0; i <= a_dly; i++) begin
            addr_ok = (i == a_dly);
            @(negedge clk);
            check("req_addr", 32'(req), 32'd1);
            check("bus_addr", bus_addr, {t_addr[31:2], 2'b00});
            check("bus_we", 32'(we), 32'(!is_ld));
            check("bus_wstrb", 32'(wstrb), is_ld ? 32'd0 : 32'(ref_strb(t_op, t_addr)));
            if (!is_ld) check("bus_wdata", bus_wdata, ref_wdata(t_op, t_st));
            step();
         end
         addr_ok = 1'b0;
         for (int i = 0; i <= d_dly; i++) begin
            data_ok = (i == d_dly);
            rdata   = (i == d_dly) ? t_rdata : $urandom;
            @(negedge clk);
            check("req_data", 32'(req), 32'd0);
            check("valid_data", 32'(out_valid), 32'd0);
            step();
         end
         data_ok = 1'b0;
      end

      for (int c = 0; c < 20 && !done; c++) begin
         out_ready = (rnd_ready && c < 19) ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         check("out_valid", 32'(out_valid), 32'd1);
         check("no_req_hold", 32'(req), 32'd0);
         if (!out_ready) begin
            check("in_ready_hold", 32'(in_ready), 32'd0);
         end else begin
            check("wd", 32'(wd_out), 32'(t_wd));
            check("wreg", 32'(wreg_out), 32'(e_wreg));
            check("wdata", wdata_out, e_wdata);
            check("pc", pc_out, t_pc);
            check("ale", 32'(ale), 32'(mis));
            check("bad_addr", bad_addr, e_bad);
            done = 1;
         end
         step();
      end
      out_ready = 1'b0;
      @(negedge clk);
      check("valid_after", 32'(out_valid), 32'd0);
      step();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 4'd0; addr = 32'h0;
      st_data = 32'h0; wd = 5'd0; wreg = 1'b0; wdata = 32'h0; pc = 32'h0;
      out_ready = 1'b0; addr_ok = 1'b0; rdata = 32'h0; data_ok = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_req", 32'(req), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_ale", 32'(ale), 32'd0);
      check("rst_wdata", wdata_out, 32'd0);
      step();

      run_txn(4'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h100, 32'h0, 0, 0, 0);
      run_txn(4'd1, 32'h1003, 32'h0, 32'h0, 5'd6, 1'b1, 32'h104, 32'h80FF_0000, 0, 0, 0);
      run_txn(4'd4, 32'h1003, 32'h0, 32'h0, 5'd7, 1'b1, 32'h108, 32'h80FF_0000, 0, 0, 0);
      run_txn(4'd7, 32'h2002, 32'hABCD, 32'h0, 5'd8, 1'b1, 32'h10C, 32'h0, 3, 0, 0);
      run_txn(4'd3, 32'h3001, 32'h0, 32'h55, 5'd9, 1'b1, 32'h110, 32'h0, 0, 0, 0);

      // Flush while a load is in its data phase.
      in_valid = 1'b1; op = 4'd3; addr = 32'h4000; wreg = 1'b1; wdata = 32'h0;
      @(negedge clk);
      step();
      in_valid = 1'b0; addr_ok = 1'b1;
      @(negedge clk);
      check("fl_req", 32'(req), 32'd1);
      step();
      addr_ok = 1'b0; flush = 1'b1;
      in_valid = 1'b1; op = 4'd0; wdata = 32'hBEEF; wd = 5'd3; pc = 32'h200;
      @(negedge clk);
      check("fl_ready0", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("fl_ready_kill", 32'(in_ready), 32'd0);
         check("fl_valid_kill", 32'(out_valid), 32'd0);
         step();
      end
      data_ok = 1'b1; rdata = 32'h1111_2222;
      @(negedge clk);
      check("fl_ready_dok", 32'(in_ready), 32'd0);
      step();
      data_ok = 1'b0;
      @(negedge clk);
      check("fl_valid_idle", 32'(out_valid), 32'd0);
      check("fl_ready_idle", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("fl_next_valid", 32'(out_valid), 32'd1);
      check("fl_next_wdata", wdata_out, 32'hBEEF);
      step();
      out_ready = 1'b0;

      // Flush in IDLE blocks acceptance.
      in_valid = 1'b1; flush = 1'b1; op = 4'd0; wdata = 32'hDEAD;
      @(negedge clk);
      check("fli_ready", 32'(in_ready), 32'd0);
      step();
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("fli_valid", 32'(out_valid), 32'd0);
      step();

      // Back-to-back non-memory bundles, out_ready 1,0,1.
      out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; wdata = 32'hA; wd = 5'd1;
      @(negedge clk);
      step();
      wdata = 32'hB; wd = 5'd2; out_ready = 1'b0;
      @(negedge clk);
      check("b2b_valid_a", 32'(out_valid), 32'd1);
      check("b2b_stall", 32'(in_ready), 32'd0);
      check("b2b_data_a0", wdata_out, 32'hA);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      check("b2b_ready", 32'(in_ready), 32'd1);
      check("b2b_data_a1", wdata_out, 32'hA);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_valid_b", 32'(out_valid), 32'd1);
      check("b2b_data_b", wdata_out, 32'hB);
      check("b2b_wd_b", 32'(wd_out), 32'd2);
      step();
      out_ready = 1'b0;
      @(negedge clk);
      check("b2b_empty", 32'(out_valid), 32'd0);
      step();

      for (int t = 0; t < 200; t++) begin
         logic [3:0]  r_op = 4'($urandom_range(0, 8));
         logic [31:0] r_addr = $urandom;
         if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
         run_txn(r_op, r_addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                 $urandom, $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
